fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Sequencer in front of the Xilinx FFT core (xfft). Accepts transform requests: size log2n and forward/inverse. Builds the 24-bit config word, including the fixed scaling schedule, and issues it on the core's config channel. Gates a raw 64-bit sample stream into the core in exact N-sample frames with generated tlast, tracks frames in flight, and drains before any reconfiguration. Sits between the sample source and xfft s_axis_config/s_axis_data; monitors xfft m_axis_data and event outputs.

## Interface
- LOG2N_MIN, 3, smallest legal log2n
- LOG2N_MAX, 12, largest legal log2n
- OUTS_W, 4, width of frames-in-flight counter
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- cfg_valid / cfg_ready  in / out  1  request handshake
- cfg_log2n  in  4  requested transform size
- cfg_fwd  in  1  1 = forward, 0 = inverse
- s_axis_tdata  in  64  {im[31:0], re[31:0]}
- s_axis_tvalid / s_axis_tready  in / out  1
- fft_cfg_tdata  out  24  to xfft s_axis_config_tdata
- fft_cfg_tvalid / fft_cfg_tready  out / in  1
- fft_data_tdata  out  64; fft_data_tvalid, fft_data_tlast  out  1; fft_data_tready  in  1
- fft_out_tvalid, fft_out_tready, fft_out_tlast  in  1  monitor taps of xfft m_axis_data
- ev_tlast_unexpected, ev_tlast_missing  in  1  xfft event pulses
- err_clr  in  1  clears err
- busy  out  1  state != IDLE
- cfg_err  out  1  one-cycle pulse: rejected request
- err  out  3  sticky {out_underflow, tlast_missing, tlast_unexpected}

## Operation
- States: IDLE, CFG, RUN, DRAIN.
- **Config word:** [3:0] log2n, [7:4] 0, [8] fwd, [20:9] scale_sch, [23:21] 0.
- **scale_sch by log2n:** ≤3 → 6; 4 → 10; 5 → 26; 6 → 42; 7 → 106; 8 → 170; 9 → 426; 10 → 682; 11 → 1706; ≥12 → 2730.
- **cfg_ready:**
  - 1 in IDLE, including during reset.
  - 1 in RUN while no request is pending.
  - 0 otherwise.
- **Request outside [LOG2N_MIN, LOG2N_MAX]:** accepted, dropped, cfg_err pulses next cycle, state and settings unchanged.
- **IDLE + legal request →** CFG. Register log2n and fwd.
- **CFG:**
  - fft_cfg_tvalid = 1; tdata held stable until handshake.
  - On handshake: active N = 2^log2n, sample counter = 0 → RUN.
- **RUN:**
  - fft_data_tdata = s_axis_tdata.
  - fft_data_tvalid = s_axis_tvalid & gate; s_axis_tready = fft_data_tready & gate.
  - fft_data_tlast = (cnt == N-1).
  - Counter increments per transferred beat and wraps to 0 after the tlast beat.
  - gate = 0 when cnt == 0 and either a request is pending or the frames-in-flight count is at its maximum. Otherwise gate = 1.
- **Legal request in RUN:** latched as pending. The current frame completes under the old config. The first cycle with cnt == 0 and pending → DRAIN.
- **DRAIN:** input gated. When frames-in-flight == 0 → CFG with the pending settings; pending clears.
- **Frames-in-flight counter:**
  - +1 on input tlast transfer.
  - −1 on fft_out_tvalid & fft_out_tready & fft_out_tlast.
  - Both in the same cycle: unchanged.
  - Decrement at 0: stays 0, sets err[2].
- **err:**
  - ev_tlast_unexpected sets err[0]; ev_tlast_missing sets err[1].
  - err_clr clears all bits; a set in the same cycle wins.
- **Reset mid-operation:** state IDLE, counters 0, pending cleared; any partial frame is abandoned.

## Timing
- **Reset values:** fft_cfg_tvalid 0, fft_data_tvalid 0, fft_data_tlast 0, s_axis_tready 0, busy 0, cfg_err 0, err 0, fft_cfg_tdata 0, cfg_ready 1.
- **Data path:** zero latency; data, valid and ready are combinational through the gate.
- **State/tready registers:** state, counters and pending are registered.
  - s_axis_tready depends on the registered gate and on fft_data_tready.
  - No combinational path from s_axis_tvalid to s_axis_tready.
- **Config handshake latency:** accept at cycle t → fft_cfg_tvalid at t+1 (from IDLE).
- **CFG → RUN:** first sample accepted no earlier than the cycle after the config handshake.
- **No valid drop:** fft_cfg_tvalid and fft_data_tvalid, once high, never drop without a handshake unless reset.

## Configuration
- **FFT_FRAME_CTRL_STATS_EN defined:**
  - Adds outputs frames_in (32) and frames_out (32).
  - They count input tlast transfers and output tlast handshakes.
  - Wrap-around; reset to 0; not cleared by err_clr.
- **Undefined:** ports and counters are absent; all other behaviour is identical.

## Structure
- **Package fft_ctrl_pkg:**
  - state enum
  - config-word field positions
  - scale-schedule function (log2n → 12 bits)
  - STAT_W = 32
- **Sub-module fft_scale_lut:** log2n → scale_sch, combinational. Used by the config-word builder.

## Test plan
- **Config word:** reset, request log2n = 9, fwd = 1 → fft_cfg_tdata = 24'h035509 held through 5 cycles of fft_cfg_tready = 0. s_axis_tready stays 0 until the handshake.
- **Framing:** two 512-beat frames with random tvalid gaps and random fft_data_tready → tlast only on beats 512 and 1024, data bit-exact.
- **Reconfigure mid-frame:** request log2n = 4, fwd = 0 at beat 100.
  - Remaining 412 beats pass.
  - Input gated until a modelled out-tlast arrives.
  - Then fft_cfg_tdata = 24'h001404, and frames are 16 beats.
- **Illegal size:** request log2n = 2 in RUN → cfg_err pulse, no fft_cfg_tvalid, framing continues at N = 512.
- **Errors:** ev_tlast_missing pulse → err = 3'b010 sticky. err_clr with a simultaneous ev_tlast_unexpected → err = 3'b001. Output tlast with zero in flight → err[2] set.
- **Reset mid-frame:** assert areset at beat 200 → next cycle all outputs at reset values. A new request restarts cleanly at beat 0.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// fft_ctrl_pkg : state type, config-word layout and scaling schedule
//                shared by fft_frame_ctrl and fft_scale_lut
// Rev 1.0
// ============================================================================
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int LOG2N_W      = 4;
  localparam int SCALE_W      = 12;
  localparam int CFG_W        = 24;
  localparam int CNT_W        = 12;
  localparam int STAT_W       = 32;

  localparam int CW_LOG2N_LSB = 0;
  localparam int CW_FWD_BIT   = 8;
  localparam int CW_SCALE_LSB = 9;

  // Fixed per-stage shift schedule; sizes outside the table clamp to the ends.
  function automatic logic [SCALE_W-1:0] scale_sch(input logic [LOG2N_W-1:0] log2n);
    logic [SCALE_W-1:0] s;
    case (log2n)
      4'd4:    s = 12'd10;
      4'd5:    s = 12'd26;
      4'd6:    s = 12'd42;
      4'd7:    s = 12'd106;
      4'd8:    s = 12'd170;
      4'd9:    s = 12'd426;
      4'd10:   s = 12'd682;
      4'd11:   s = 12'd1706;
      default: s = (log2n < 4'd4) ? 12'd6 : 12'd2730;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_scale_lut.sv
`default_nettype none
// ============================================================================
// fft_scale_lut : combinational log2n -> scale_sch lookup
// Rev 1.0
// ============================================================================
module fft_scale_lut
  import fft_ctrl_pkg::*;
(
  input  logic [LOG2N_W-1:0] log2n_i,
  output logic [SCALE_W-1:0] scale_sch_o
);

  assign scale_sch_o = scale_sch(log2n_i);

endmodule
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// fft_frame_ctrl : xfft request sequencer, config issue and N-sample framing
//   Optional FFT_FRAME_CTRL_STATS_EN adds frames_in / frames_out counters.
// Rev 1.0
// ============================================================================
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N_MIN = 3,
  parameter int LOG2N_MAX = 12,
  parameter int OUTS_W    = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LOG2N_W-1:0]   cfg_log2n,
  input  logic                 cfg_fwd,
  input  logic [63:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [CFG_W-1:0]     fft_cfg_tdata,
  output logic                 fft_cfg_tvalid,
  input  logic                 fft_cfg_tready,
  output logic [63:0]          fft_data_tdata,
  output logic                 fft_data_tvalid,
  output logic                 fft_data_tlast,
  input  logic                 fft_data_tready,
  input  logic                 fft_out_tvalid,
  input  logic                 fft_out_tready,
  input  logic                 fft_out_tlast,
  input  logic                 ev_tlast_unexpected,
  input  logic                 ev_tlast_missing,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 cfg_err,
  output logic [2:0]           err
`ifdef FFT_FRAME_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]    frames_in,
  output logic [STAT_W-1:0]    frames_out
`endif
);

  localparam logic [LOG2N_W-1:0] L2_MIN = LOG2N_W'(LOG2N_MIN);
  localparam logic [LOG2N_W-1:0] L2_MAX = LOG2N_W'(LOG2N_MAX);

  state_e               state_q, state_d;
  logic [CFG_W-1:0]     cfg_word_q, cfg_word_d;
  logic [LOG2N_W-1:0]   cfg_log2n_q, cfg_log2n_d;
  logic [CNT_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [LOG2N_W-1:0]   pend_log2n_q, pend_log2n_d;
  logic                 pend_fwd_q, pend_fwd_d;
  logic [OUTS_W-1:0]    outs_q, outs_d;
  logic [2:0]           err_q, err_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 w_legal, w_cfg_hs, w_run, w_gate, w_tlast;
  logic                 w_beat, w_in_last, w_out_last, w_underflow;
  logic [LOG2N_W-1:0]   w_bld_log2n;
  logic                 w_bld_fwd;
  logic [SCALE_W-1:0]   w_scale;
  logic [CFG_W-1:0]     w_word;

  assign w_legal  = (cfg_log2n >= L2_MIN) && (cfg_log2n <= L2_MAX);
  assign w_cfg_hs = cfg_valid & cfg_ready;
  assign w_run    = (state_q == ST_RUN);
  // Gate only closes on a frame boundary, so a frame in progress always completes.
  assign w_gate   = ~((cnt_q == '0) & (pend_q | (outs_q == '1)));
  assign w_tlast  = (cnt_q == last_q);

  assign w_beat      = w_run & w_gate & s_axis_tvalid & fft_data_tready;
  assign w_in_last   = w_beat & w_tlast;
  assign w_out_last  = fft_out_tvalid & fft_out_tready & fft_out_tlast;
  assign w_underflow = w_out_last & ~w_in_last & (outs_q == '0);

  // The word is built from the live request in IDLE, from the pending one otherwise.
  assign w_bld_log2n = (state_q == ST_IDLE) ? cfg_log2n : pend_log2n_q;
  assign w_bld_fwd   = (state_q == ST_IDLE) ? cfg_fwd   : pend_fwd_q;

  fft_scale_lut u_scale_lut (
    .log2n_i     (w_bld_log2n),
    .scale_sch_o (w_scale)
  );

  always_comb begin
    w_word = '0;
    w_word[CW_LOG2N_LSB +: LOG2N_W] = w_bld_log2n;
    w_word[CW_FWD_BIT]              = w_bld_fwd;
    w_word[CW_SCALE_LSB +: SCALE_W] = w_scale;
  end

  assign cfg_ready       = (state_q == ST_IDLE) | (w_run & ~pend_q);
  assign fft_cfg_tvalid  = (state_q == ST_CFG);
  assign fft_cfg_tdata   = cfg_word_q;
  assign fft_data_tdata  = s_axis_tdata;
  assign fft_data_tvalid = w_run & w_gate & s_axis_tvalid;
  assign s_axis_tready   = w_run & w_gate & fft_data_tready;
  assign fft_data_tlast  = w_run & w_tlast;
  assign busy            = (state_q != ST_IDLE);
  assign cfg_err         = cfg_err_q;
  assign err             = err_q;

  always_comb begin
    state_d      = state_q;
    cfg_word_d   = cfg_word_q;
    cfg_log2n_d  = cfg_log2n_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_log2n_d = pend_log2n_q;
    pend_fwd_d   = pend_fwd_q;
    outs_d       = outs_q;
    cfg_err_d    = w_cfg_hs & ~w_legal;
    err_d        = (err_clr ? 3'b000 : err_q)
                 | {w_underflow, ev_tlast_missing, ev_tlast_unexpected};

    unique case (state_q)
      ST_IDLE: begin
        if (w_cfg_hs && w_legal) begin
          state_d     = ST_CFG;
          cfg_word_d  = w_word;
          cfg_log2n_d = cfg_log2n;
        end
      end
      ST_CFG: begin
        if (fft_cfg_tready) begin
          state_d = ST_RUN;
          last_d  = CNT_W'((13'd1 << cfg_log2n_q) - 13'd1);
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (w_beat) cnt_d = w_tlast ? '0 : cnt_q + CNT_W'(1);
        if ((cnt_q == '0) && pend_q) begin
          state_d = ST_DRAIN;
        end else if (w_cfg_hs && w_legal) begin
          pend_d       = 1'b1;
          pend_log2n_d = cfg_log2n;
          pend_fwd_d   = cfg_fwd;
        end
      end
      ST_DRAIN: begin
        if (outs_q == '0) begin
          state_d     = ST_CFG;
          cfg_word_d  = w_word;
          cfg_log2n_d = pend_log2n_q;
          pend_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_in_last && !w_out_last) begin
      outs_d = outs_q + OUTS_W'(1);
    end else if (w_out_last && !w_in_last && (outs_q != '0)) begin
      outs_d = outs_q - OUTS_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cfg_word_q   <= '0;
      cfg_log2n_q  <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_log2n_q <= '0;
      pend_fwd_q   <= 1'b0;
      outs_q       <= '0;
      err_q        <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_word_q   <= cfg_word_d;
      cfg_log2n_q  <= cfg_log2n_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_log2n_q <= pend_log2n_d;
      pend_fwd_q   <= pend_fwd_d;
      outs_q       <= outs_d;
      err_q        <= err_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

`ifdef FFT_FRAME_CTRL_STATS_EN
  logic [STAT_W-1:0] frames_in_q, frames_out_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      frames_in_q  <= '0;
      frames_out_q <= '0;
    end else begin
      if (w_in_last)  frames_in_q  <= frames_in_q + STAT_W'(1);
      if (w_out_last) frames_out_q <= frames_out_q + STAT_W'(1);
    end
  end

  assign frames_in  = frames_in_q;
  assign frames_out = frames_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_ctrl : directed self-checking bench for fft_frame_ctrl
// Rev 1.0
// ============================================================================
module tb_fft_frame_ctrl;

  logic        aclk;
  logic        areset;
  logic        cfg_valid, cfg_ready, cfg_fwd;
  logic [3:0]  cfg_log2n;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [23:0] fft_cfg_tdata;
  logic        fft_cfg_tvalid, fft_cfg_tready;
  logic [63:0] fft_data_tdata;
  logic        fft_data_tvalid, fft_data_tlast, fft_data_tready;
  logic        fft_out_tvalid, fft_out_tready, fft_out_tlast;
  logic        ev_tlast_unexpected, ev_tlast_missing, err_clr;
  logic        busy, cfg_err;
  logic [2:0]  err;
`ifdef FFT_FRAME_CTRL_STATS_EN
  logic [31:0] frames_in, frames_out;
`endif

  fft_frame_ctrl dut (
    .aclk                (aclk),
    .areset              (areset),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .cfg_log2n           (cfg_log2n),
    .cfg_fwd             (cfg_fwd),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .fft_cfg_tdata       (fft_cfg_tdata),
    .fft_cfg_tvalid      (fft_cfg_tvalid),
    .fft_cfg_tready      (fft_cfg_tready),
    .fft_data_tdata      (fft_data_tdata),
    .fft_data_tvalid     (fft_data_tvalid),
    .fft_data_tlast      (fft_data_tlast),
    .fft_data_tready     (fft_data_tready),
    .fft_out_tvalid      (fft_out_tvalid),
    .fft_out_tready      (fft_out_tready),
    .fft_out_tlast       (fft_out_tlast),
    .ev_tlast_unexpected (ev_tlast_unexpected),
    .ev_tlast_missing    (ev_tlast_missing),
    .err_clr             (err_clr),
    .busy                (busy),
    .cfg_err             (cfg_err),
    .err                 (err)
`ifdef FFT_FRAME_CTRL_STATS_EN
    ,
    .frames_in           (frames_in),
    .frames_out          (frames_out)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_checks, n_errors;
  int          model_n, beat_cnt, total_beats, dut_lasts, outs_done;
  int unsigned src_seq;
  logic        src_en, rnd_ready;

  function automatic logic [63:0] mk(input int unsigned s);
    return {s ^ 32'hA5A5_0000, s * 32'h9E37_79B1};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One clock: monitor at negedge, then advance the source model after the edge.
  task automatic cycle();
    logic xfer, last_obs;
    @(negedge aclk);
    xfer = fft_data_tvalid && fft_data_tready && !areset;
    last_obs = xfer && fft_data_tlast;
    if (xfer) begin
      check("data", fft_data_tdata, mk(src_seq));
      check("tlast", fft_data_tlast, beat_cnt == model_n - 1);
    end
    @(posedge aclk);
    #1;
    if (xfer) begin
      src_seq++;
      total_beats++;
      beat_cnt = (beat_cnt == model_n - 1) ? 0 : beat_cnt + 1;
      if (last_obs) dut_lasts++;
    end
    if (!src_en)                         s_axis_tvalid = 1'b0;
    else if (!(s_axis_tvalid && !xfer))  s_axis_tvalid = ($urandom_range(3) != 0);
    fft_data_tready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
    s_axis_tdata    = mk(src_seq);
    #1;
  endtask

  task automatic run_until_lasts(input int n, input string tag);
    int k = 0;
    while (dut_lasts < n && k < 6000) begin
      cycle();
      k++;
    end
    check(tag, dut_lasts, n);
  endtask

  task automatic run_until_beat(input int b, input string tag);
    int k = 0;
    while (beat_cnt != b && k < 6000) begin
      cycle();
      k++;
    end
    check(tag, beat_cnt, b);
  endtask

  task automatic out_pulses(input int n);
    fft_out_tvalid = 1'b1;
    fft_out_tready = 1'b1;
    fft_out_tlast  = 1'b1;
    repeat (n) cycle();
    fft_out_tvalid = 1'b0;
    fft_out_tready = 1'b0;
    fft_out_tlast  = 1'b0;
    outs_done += n;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_cfg_tvalid"},  fft_cfg_tvalid,  0);
    check({tag, "_data_tvalid"}, fft_data_tvalid, 0);
    check({tag, "_data_tlast"},  fft_data_tlast,  0);
    check({tag, "_s_tready"},    s_axis_tready,   0);
    check({tag, "_busy"},        busy,            0);
    check({tag, "_cfg_err"},     cfg_err,         0);
    check({tag, "_err"},         err,             0);
    check({tag, "_cfg_tdata"},   fft_cfg_tdata,   0);
    check({tag, "_cfg_ready"},   cfg_ready,       1);
  endtask

  task automatic do_cfg(input logic [3:0] l2, input logic fw, input logic [23:0] exp);
    cfg_log2n = l2;
    cfg_fwd   = fw;
    cfg_valid = 1'b1;
    check("cfg_ready_idle", cfg_ready, 1);
    cycle();
    cfg_valid = 1'b0;
    check("cfg_tvalid_up", fft_cfg_tvalid, 1);
    check("cfg_word", fft_cfg_tdata, exp);
    fft_cfg_tready = 1'b1;
    cycle();
    fft_cfg_tready = 1'b0;
    check("cfg_tvalid_done", fft_cfg_tvalid, 0);
    model_n  = 1 << l2;
    beat_cnt = 0;
  endtask

  initial begin
    int k;
    n_checks = 0; n_errors = 0;
    model_n = 512; beat_cnt = 0; total_beats = 0; dut_lasts = 0; outs_done = 0;
    src_seq = 0; src_en = 1'b0; rnd_ready = 1'b0;
    areset = 1'b1; cfg_valid = 1'b0; cfg_log2n = '0; cfg_fwd = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; fft_cfg_tready = 1'b0; fft_data_tready = 1'b0;
    fft_out_tvalid = 1'b0; fft_out_tready = 1'b0; fft_out_tlast = 1'b0;
    ev_tlast_unexpected = 1'b0; ev_tlast_missing = 1'b0; err_clr = 1'b0;

    repeat (3) cycle();
    check_rst("rst");
    areset = 1'b0;
    cycle();

    // Config word held while the core stalls the config channel.
    cfg_log2n = 4'd9; cfg_fwd = 1'b1; cfg_valid = 1'b1;
    check("cfg_ready_idle", cfg_ready, 1);
    cycle();
    cfg_valid = 1'b0;
    check("cfg_tvalid_t1", fft_cfg_tvalid, 1);
    check("cfg_word_9f", fft_cfg_tdata, 24'h035509);
    check("busy_cfg", busy, 1);
    check("cfg_ready_cfg", cfg_ready, 0);
    src_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("cfg_hold_tvalid", fft_cfg_tvalid, 1);
      check("cfg_hold_word", fft_cfg_tdata, 24'h035509);
      check("cfg_hold_s_tready", s_axis_tready, 0);
    end
    fft_cfg_tready = 1'b1;
    cycle();
    fft_cfg_tready = 1'b0;
    check("cfg_tvalid_done", fft_cfg_tvalid, 0);
    model_n = 512; beat_cnt = 0;
    rnd_ready = 1'b1;

    // Two 512-beat frames with random stalls on both sides.
    run_until_lasts(2, "two_frames");
    check("beats_two_frames", total_beats, 1024);

    // Out-of-range size is rejected without touching the running config.
    run_until_beat(50, "reach_beat50");
    cfg_log2n = 4'd2; cfg_fwd = 1'b1; cfg_valid = 1'b1;
    check("cfg_ready_run", cfg_ready, 1);
    cycle();
    cfg_valid = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    check("illegal_no_cfg", fft_cfg_tvalid, 0);
    cycle();
    check("cfg_err_clear", cfg_err, 0);
    check("cfg_ready_nopend", cfg_ready, 1);

    // Reconfigure mid-frame: old frame finishes at 512, then drain.
    run_until_beat(100, "reach_beat100");
    cfg_log2n = 4'd4; cfg_fwd = 1'b0; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    check("cfg_ready_pend", cfg_ready, 0);
    check("legal_no_err", cfg_err, 0);
    run_until_lasts(3, "third_frame");
    check("beats_three_frames", total_beats, 1536);
    rnd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("drain_s_tready", s_axis_tready, 0);
      check("drain_data_tvalid", fft_data_tvalid, 0);
      check("drain_cfg_tvalid", fft_cfg_tvalid, 0);
    end
    out_pulses(3);
    k = 0;
    while (!fft_cfg_tvalid && k < 5) begin
      cycle();
      k++;
    end
    check("recfg_tvalid", fft_cfg_tvalid, 1);
    check("recfg_word", fft_cfg_tdata, 24'h001404);
    fft_cfg_tready = 1'b1;
    cycle();
    fft_cfg_tready = 1'b0;
    model_n = 16;
    rnd_ready = 1'b1;
    run_until_lasts(5, "small_frames");
    check("beats_small_frames", total_beats, 1568);

    // Sticky error bits and clear-vs-set priority.
    ev_tlast_missing = 1'b1;
    cycle();
    ev_tlast_missing = 1'b0;
    check("err_missing", err, 3'b010);
    repeat (3) cycle();
    check("err_sticky", err, 3'b010);
    err_clr = 1'b1; ev_tlast_unexpected = 1'b1;
    cycle();
    err_clr = 1'b0; ev_tlast_unexpected = 1'b0;
    check("err_clr_vs_set", err, 3'b001);

    // Retire exactly the frames in flight, then one more to underflow.
    src_en = 1'b0;
    repeat (2) cycle();
    out_pulses(dut_lasts - outs_done);
    check("err_no_underflow", err, 3'b001);
    out_pulses(1);
    check("err_underflow", err, 3'b101);

    areset = 1'b1;
    cycle();
    areset = 1'b0;
    check("err_after_reset", err, 3'b000);
    beat_cnt = 0; total_beats = 0; dut_lasts = 0; outs_done = 0;

    // Reset in the middle of a 512 frame, then a clean restart at N = 8.
    src_en = 1'b1;
    do_cfg(4'd9, 1'b1, 24'h035509);
    run_until_beat(200, "reach_beat200");
    areset = 1'b1;
    cycle();
    check_rst("midrst");
    areset = 1'b0;
    beat_cnt = 0; total_beats = 0; dut_lasts = 0;
    do_cfg(4'd3, 1'b1, 24'h000D03);
    run_until_lasts(2, "restart_frames");
    check("beats_restart", total_beats, 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
